dm_banked_ram: RTL and testbench

//  Parametrised data memory for the Mipu datapath; successor to the fixed 16-bit DM.

---
 rtl/dm_banked_ram_pkg.sv | 18 +
 rtl/dm_clear_seq.sv | 54 +++++
 rtl/dm_banked_ram.sv | 108 ++++++++++
 tb/tb_dm_banked_ram.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_banked_ram_pkg.sv
// Shared types and defaults for the banked data memory.
// Holds the clear-sequencer state encoding and default widths.
package dm_banked_ram_pkg;

  localparam int DM_DATA_W = 16;
  localparam int DM_ADDR_W = 8;
  localparam int DM_BYTE_W = 8;

  typedef enum logic {
    DM_ST_CLEAR = 1'b0,
    DM_ST_READY = 1'b1
  } dm_state_t;

  function automatic int dm_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_clear_seq.sv
// Post-reset clear sequencer: walks every word once,
// then hands the write port to the user path.
module dm_clear_seq
  import dm_banked_ram_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = dm_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output logic             busy
);

  localparam int LAST_I = DEPTH - 1;
  localparam logic [ADDR_W:0] LAST = LAST_I[ADDR_W:0];

  dm_state_t       state;
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DM_ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        DM_ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= DM_ST_READY;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DM_ST_READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= DM_ST_CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt[IDX_W-1:0];

endmodule

// File: rtl/dm_banked_ram.sv
// Byte-lane data memory with registered read, range check
// and a self-clearing fill after reset.
module dm_banked_ram
  import dm_banked_ram_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH  = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      din,
  input  logic                   we,
  input  logic [DATA_W/8-1:0]    be,
  input  logic                   re,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int NB    = DATA_W / DM_BYTE_W;
  localparam int IDX_W = dm_idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              usr_we;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  dm_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Extra top bit keeps DEPTH == 2**ADDR_W from aliasing to zero.
  assign in_range = {1'b0, addr} < DEPTH_W;
  assign idx      = addr[IDX_W-1:0];
  assign old_word = mem[idx];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged[i*8 +: 8] = be[i] ? din[i*8 +: 8]
                                    : old_word[i*8 +: 8];
  end

  assign usr_we = !busy && we && in_range && (|be);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = merged;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_idx  = clr_addr;
      wr_data = INIT_VAL;
    end else if (usr_we) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else if (busy) begin
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= (we || re) && !in_range;
      dout_valid <= re;
      if (re) begin
        // Write-first: a same-cycle write shows through on the read.
        if (!in_range) begin
          dout <= '0;
        end else if (we) begin
          dout <= merged;
        end else begin
          dout <= old_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_banked_ram.sv
// Directed self-checking bench for dm_banked_ram
// (DEPTH=16, DATA_W=16, INIT_VAL=16'hA5A5).
module tb_dm_banked_ram;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              we;
  logic [1:0]        be;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model [0:DEPTH-1];

  always #5 clk = ~clk;

  dm_banked_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .be         (be),
    .re         (re),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic [15:0] exp,
                    input string tag);
    addr = a[ADDR_W-1:0];
    re   = 1'b1;
    tick();
    re = 1'b0;
    check({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
    check({tag, "_dout"}, {16'd0, dout}, {16'd0, exp});
  endtask

  task automatic wr(input int a, input logic [15:0] d,
                    input logic [1:0] b, input string tag);
    addr = a[ADDR_W-1:0];
    din  = d;
    be   = b;
    we   = 1'b1;
    tick();
    we = 1'b0;
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, model[a], $sformatf("%s%0d", tag, a));
    end
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      check({tag, "_busy_valid"}, {31'd0, dout_valid}, 32'd0);
      check({tag, "_busy_err"}, {31'd0, err}, 32'd0);
      n++;
      tick();
    end
    check({tag, "_busy_len"}, n, 32'd16);
  endtask

  initial begin
    reset = 1'b0;
    addr  = '0;
    din   = '0;
    we    = 1'b0;
    be    = 2'b00;
    re    = 1'b0;
    for (int a = 0; a < DEPTH; a++) model[a] = INIT;

    // Reset state and clear length
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    wait_clear("c1");
    sweep("init");

    // Byte-lane writes
    wr(3, 16'h1234, 2'b01, "w3a");
    model[3] = 16'hA534;
    rd(3, model[3], "r3a");
    wr(3, 16'hBEEF, 2'b10, "w3b");
    model[3] = 16'hBE34;
    rd(3, model[3], "r3b");

    // Same-cycle write and read is write-first
    addr = 8'd5;
    din  = 16'h00FF;
    be   = 2'b11;
    we   = 1'b1;
    re   = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b0;
    model[5] = 16'h00FF;
    check("wf_valid", {31'd0, dout_valid}, 32'd1);
    check("wf_dout", {16'd0, dout}, 32'h00FF);
    check("wf_err", {31'd0, err}, 32'd0);

    // we with be=0 changes nothing
    wr(7, 16'h0000, 2'b00, "wbe0");
    rd(7, INIT, "rbe0");

    // Out of range read and write
    addr = 8'd16;
    re   = 1'b1;
    tick();
    re = 1'b0;
    check("oor_rd_err", {31'd0, err}, 32'd1);
    check("oor_rd_dout", {16'd0, dout}, 32'd0);
    check("oor_rd_valid", {31'd0, dout_valid}, 32'd1);
    addr = 8'd200;
    din  = 16'hFFFF;
    be   = 2'b11;
    we   = 1'b1;
    tick();
    we = 1'b0;
    check("oor_wr_err", {31'd0, err}, 32'd1);
    check("oor_wr_valid", {31'd0, dout_valid}, 32'd0);
    tick();
    check("err_pulse", {31'd0, err}, 32'd0);
    sweep("oor");

    // dout holds when no read is issued
    wr(3, 16'h1234, 2'b11, "w3c");
    model[3] = 16'h1234;
    rd(3, model[3], "r3c");
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold%0d_dout", k), {16'd0, dout}, 32'h1234);
      check($sformatf("hold%0d_valid", k), {31'd0, dout_valid}, 32'd0);
    end

    // Reset mid-clear restarts; requests during busy are ignored
    reset = 1'b0;
    tick();
    reset = 1'b1;
    addr = 8'd0;
    din  = 16'h1111;
    be   = 2'b11;
    we   = 1'b1;
    re   = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst2_busy", {31'd0, busy}, 32'd1);
    wait_clear("c2");
    we = 1'b0;
    re = 1'b0;
    check("c2_end_valid", {31'd0, dout_valid}, 32'd0);
    for (int a = 0; a < DEPTH; a++) model[a] = INIT;
    sweep("clr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
